stopwatch_timer: RTL and testbench
==================================

Name: stopwatch_timer

Overview:
- Parametrised successor to the basic elapsed-time counter. Provides an up-counting stopwatch and a down-counting preset timer, with lap capture, a per-second tick and a completion pulse.
- Outputs are binary HH:MM:SS and feed the display/BCD stage.
- Sits between the debounced front-panel buttons and the display formatter.

Parameters:
- TICKS_PER_SEC, 25175000, clock cycles per second; minimum 2.
- HOURS_MAX, 99, highest hour value before wrap; range 1..255.
- PW, $clog2(TICKS_PER_SEC), prescaler width (derived; not overridden).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start_stop  input  1  async level; each synchronised rising edge toggles run state
- clear  input  1  synchronous; zeroes time and prescaler, stops, drops lap_valid
- load  input  1  synchronous; when stopped, loads preset into time
- mode  input  1  0 = count up, 1 = count down; latched on start
- preset_sec  input  8  load value, seconds
- preset_min  input  8  load value, minutes
- preset_hr  input  8  load value, hours
- lap  input  1  async level; each synchronised rising edge captures current time
- seconds  output  8  current seconds, 0..59
- minutes  output  8  current minutes, 0..59
- hours  output  8  current hours, 0..HOURS_MAX
- lap_sec  output  8  captured seconds
- lap_min  output  8  captured minutes
- lap_hr  output  8  captured hours
- lap_valid  output  1  high once a lap has been captured since the last clear or reset
- running  output  1  run state
- tick  output  1  one-cycle pulse on each second increment/decrement
- done  output  1  one-cycle pulse when down count reaches 00:00:00

Behaviour:
- Reset (async) sets all outputs, the prescaler, the synchronisers and the latched mode to 0.
- start_stop and lap each pass through a 2-flop synchroniser plus an edge detector. Input rise to effect is 3 clock edges.
- Priority per cycle: clear > load > start_stop edge > tick. Lap capture is independent of this chain.
- clear: time = 0, prescaler = 0, running = 0, lap outputs = 0, lap_valid = 0. The lap edge is ignored that cycle.
- load (running = 0 only): time = clamp(preset), where sec/min values above 59 become 59 and hr above HOURS_MAX becomes HOURS_MAX. Prescaler = 0. load is ignored while running.
- start_stop edge while stopped: running = 1 and mode_q = mode.
  - Exception: in down mode with time = 00:00:00, running stays 0.
- start_stop edge while running: running = 0. The prescaler holds its value, so a resume continues the partial second.
- mode changes while running have no effect until the next start.
- Prescaler: while running, counts 0..TICKS_PER_SEC-1. At terminal count it wraps to 0 and the time updates on that same edge. tick is high for that one cycle, registered with the update.
- Up mode: sec 59 -> 0 with carry; min 59 -> 0 with carry; hr HOURS_MAX -> 0, keeps running and gives no done.
- Down mode: sec 0 -> 59 with borrow; min 0 -> 59 with borrow. On the transition to 00:00:00: running = 0, done = 1 for one cycle (same cycle as tick), prescaler = 0.
- Lap edge: {lap_hr, lap_min, lap_sec} = the time value registered before any same-cycle tick update; lap_valid = 1. Works in any run state.
- If a start_stop edge and a terminal tick coincide while running: stop takes priority and the tick is suppressed. Time is unchanged and the prescaler holds at terminal count, so it ticks immediately on resume.
- Reset asserted mid-count: immediate clear; on release, counting resumes only after a new start_stop edge.

Test Plan:
- TICKS_PER_SEC=4, HOURS_MAX=2. Release reset, pulse start_stop, run 4×60 cycles -> minutes=1, seconds=0; tick count = 60; running=1; first tick 4 cycles after running rises.
- Up wrap: load 02:59:58 (stopped), mode=0, start; after 8 cycles -> 00:00:00, running=1, done never pulses.
- Down: load 00:01:01, mode=1, start; after 4 cycles -> 00:01:00; after 4 more -> 00:00:59; after 61 seconds total -> 00:00:00, done one cycle coincident with tick, running=0. A further start_stop edge leaves running=0.
- Clamp/ignore: load preset 05:75:80 -> 02:59:59. While running, assert load with 00:00:00 -> time unchanged.
- Pause and lap: stop after 6 cycles of running (prescaler=2), wait 50 cycles with time frozen, resume -> next tick after 2 cycles. Lap edge at 00:00:03 -> lap_sec=3, lap_valid=1; clear -> lap_valid=0, all time 0.
- Async reset asserted mid-second with start_stop held high -> outputs 0 immediately. After release, no edge is detected until start_stop goes low then high.

Source files
------------

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: up-counting stopwatch / down-counting preset timer with lap
// capture, a per-second tick and a completion pulse. Time is kept as binary
// HH:MM:SS for the downstream BCD/display stage.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   start_stop, lap         async button levels; each synchronised rising edge
//                           toggles run state / captures the current time
//   clear, load, mode       synchronous controls; mode is latched on start
//   preset_hr/min/sec       load value (clamped to legal ranges)
//   hours/minutes/seconds   current time
//   lap_hr/min/sec, lap_valid  captured time and capture flag
//   running, tick, done     run state, one-cycle second pulse, down-count end
module stopwatch_timer #(
  parameter int TICKS_PER_SEC = 25175000,
  parameter int HOURS_MAX     = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       load,
  input  logic       mode,
  input  logic [7:0] preset_sec,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_hr,
  input  logic       lap,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic [7:0] lap_sec,
  output logic [7:0] lap_min,
  output logic [7:0] lap_hr,
  output logic       lap_valid,
  output logic       running,
  output logic       tick,
  output logic       done
);

  localparam int             PW   = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]  TERM = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]     HMAX = 8'(HOURS_MAX);

  logic [PW-1:0] presc;
  logic          mode_q;

  // Button synchronisers and edge detectors
  logic ss_s1, ss_s2, ss_prev, ss_arm;
  logic lp_s1, lp_s2, lp_prev, lp_arm;
  logic live;
  logic ss_edge, lp_edge;

  // An edge only counts once the synchronised input has been seen low after
  // reset, so a button held through reset does not register as a press.
  // live marks that s1 carries a real sample rather than its reset value.
  assign ss_edge = ss_s2 & ~ss_prev & ss_arm;
  assign lp_edge = lp_s2 & ~lp_prev & lp_arm;

  // Next time value for a one-second step in the latched direction
  logic [7:0] sec_n, min_n, hr_n;
  logic       next_zero, time_zero;

  always_comb begin
    sec_n = seconds;
    min_n = minutes;
    hr_n  = hours;
    if (!mode_q) begin
      if (seconds == 8'd59) begin
        sec_n = 8'd0;
        if (minutes == 8'd59) begin
          min_n = 8'd0;
          hr_n  = (hours == HMAX) ? 8'd0 : hours + 8'd1;
        end else begin
          min_n = minutes + 8'd1;
        end
      end else begin
        sec_n = seconds + 8'd1;
      end
    end else begin
      if (seconds == 8'd0) begin
        sec_n = 8'd59;
        if (minutes == 8'd0) begin
          min_n = 8'd59;
          hr_n  = hours - 8'd1;
        end else begin
          min_n = minutes - 8'd1;
        end
      end else begin
        sec_n = seconds - 8'd1;
      end
    end
  end

  assign next_zero = (sec_n == 8'd0) && (min_n == 8'd0) && (hr_n == 8'd0);
  assign time_zero = (seconds == 8'd0) && (minutes == 8'd0) && (hours == 8'd0);

  // Clamped preset
  logic [7:0] sec_ld, min_ld, hr_ld;
  assign sec_ld = (preset_sec > 8'd59) ? 8'd59 : preset_sec;
  assign min_ld = (preset_min > 8'd59) ? 8'd59 : preset_min;
  assign hr_ld  = (preset_hr  > HMAX)  ? HMAX  : preset_hr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_s1     <= 1'b0;
      ss_s2     <= 1'b0;
      ss_prev   <= 1'b0;
      ss_arm    <= 1'b0;
      lp_s1     <= 1'b0;
      lp_s2     <= 1'b0;
      lp_prev   <= 1'b0;
      lp_arm    <= 1'b0;
      live      <= 1'b0;
      presc     <= '0;
      mode_q    <= 1'b0;
      seconds   <= 8'd0;
      minutes   <= 8'd0;
      hours     <= 8'd0;
      lap_sec   <= 8'd0;
      lap_min   <= 8'd0;
      lap_hr    <= 8'd0;
      lap_valid <= 1'b0;
      running   <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ss_s1   <= start_stop;
      ss_s2   <= ss_s1;
      ss_prev <= ss_s2;
      ss_arm  <= ss_arm | (live & ~ss_s1);
      lp_s1   <= lap;
      lp_s2   <= lp_s1;
      lp_prev <= lp_s2;
      lp_arm  <= lp_arm | (live & ~lp_s1);
      live    <= 1'b1;

      tick <= 1'b0;
      done <= 1'b0;

      if (clear) begin
        seconds   <= 8'd0;
        minutes   <= 8'd0;
        hours     <= 8'd0;
        presc     <= '0;
        running   <= 1'b0;
        lap_sec   <= 8'd0;
        lap_min   <= 8'd0;
        lap_hr    <= 8'd0;
        lap_valid <= 1'b0;
      end else begin
        // Lap sees the time as registered, ahead of any same-cycle tick
        if (lp_edge) begin
          lap_sec   <= seconds;
          lap_min   <= minutes;
          lap_hr    <= hours;
          lap_valid <= 1'b1;
        end

        if (load && !running) begin
          seconds <= sec_ld;
          minutes <= min_ld;
          hours   <= hr_ld;
          presc   <= '0;
        end else if (ss_edge) begin
          // Prescaler holds across stop/start so a resume finishes the
          // partial second; a stop on terminal count suppresses that tick.
          if (running) begin
            running <= 1'b0;
          end else if (!(mode && time_zero)) begin
            running <= 1'b1;
            mode_q  <= mode;
          end
        end else if (running) begin
          if (presc == TERM) begin
            presc   <= '0;
            seconds <= sec_n;
            minutes <= min_n;
            hours   <= hr_n;
            tick    <= 1'b1;
            if (mode_q && next_zero) begin
              running <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: table of load/clear vectors, hand sequences for
// multi-cycle behaviour, and randomized stimulus checked every cycle against a
// reference model that keeps time as a total-seconds integer.
module tb_stopwatch_timer;
  localparam int TPS    = 4;
  localparam int HM     = 2;
  localparam int PERIOD = (HM + 1) * 3600;

  logic clock = 1'b0, reset = 1'b0;
  logic start_stop = 1'b0, clear = 1'b0, load = 1'b0, mode = 1'b0, lap = 1'b0;
  logic [7:0] preset_sec = 8'd0, preset_min = 8'd0, preset_hr = 8'd0;
  logic [7:0] seconds, minutes, hours, lap_sec, lap_min, lap_hr;
  logic lap_valid, running, tick, done;

  int total = 0;
  int bad   = 0;

  stopwatch_timer #(.TICKS_PER_SEC(TPS), .HOURS_MAX(HM)) dut (
    .clock(clock), .reset(reset), .start_stop(start_stop), .clear(clear),
    .load(load), .mode(mode), .preset_sec(preset_sec), .preset_min(preset_min),
    .preset_hr(preset_hr), .lap(lap), .seconds(seconds), .minutes(minutes),
    .hours(hours), .lap_sec(lap_sec), .lap_min(lap_min), .lap_hr(lap_hr),
    .lap_valid(lap_valid), .running(running), .tick(tick), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int t = 0, pre = 0, lap_t = 0;
  bit run = 0, mq = 0, lv = 0, m_tick = 0, m_done = 0;
  bit ssh[$];
  bit lph[$];

  function automatic int cl(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // A press registers at edge k when the samples taken at edges k-2 and k-3
  // (counted from reset release) were 1 and 0.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      t = 0; pre = 0; lap_t = 0; run = 0; mq = 0; lv = 0; m_tick = 0; m_done = 0;
      ssh.delete(); lph.delete();
    end else begin
      int  k;
      bit  sse, lpe;
      ssh.push_back(start_stop);
      lph.push_back(lap);
      k   = ssh.size();
      sse = (k >= 4) && ssh[k-3] && !ssh[k-4];
      lpe = (k >= 4) && lph[k-3] && !lph[k-4];
      m_tick = 0;
      m_done = 0;
      if (clear) begin
        t = 0; pre = 0; run = 0; lap_t = 0; lv = 0;
      end else begin
        if (lpe) begin lap_t = t; lv = 1; end
        if (load && !run) begin
          t = cl(int'(preset_hr), HM) * 3600 + cl(int'(preset_min), 59) * 60 + cl(int'(preset_sec), 59);
          pre = 0;
        end else if (sse) begin
          if (run) run = 0;
          else if (!(mode && t == 0)) begin run = 1; mq = mode; end
        end else if (run) begin
          if (pre == TPS - 1) begin
            pre = 0;
            m_tick = 1;
            if (!mq) t = (t + 1) % PERIOD;
            else begin
              t = t - 1;
              if (t == 0) begin run = 0; m_done = 1; end
            end
          end else begin
            pre++;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    logic [51:0] a, e;
    a = {hours, minutes, seconds, lap_hr, lap_min, lap_sec, lap_valid, running, tick, done};
    e = {8'(t / 3600), 8'((t / 60) % 60), 8'(t % 60),
         8'(lap_t / 3600), 8'((lap_t / 60) % 60), 8'(lap_t % 60),
         lv, run, m_tick, m_done};
    chk("model", 64'(a), 64'(e));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns just after the edge on which the press takes effect
  task automatic press_ss();
    start_stop = 1'b1; @(negedge clock);
    start_stop = 1'b0; @(negedge clock);
    @(negedge clock);
  endtask

  task automatic press_lap();
    lap = 1'b1; @(negedge clock);
    lap = 1'b0; @(negedge clock);
    @(negedge clock);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    preset_hr = 8'(h); preset_min = 8'(m); preset_sec = 8'(s);
    load = 1'b1; @(negedge clock);
    load = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; @(negedge clock);
    clear = 1'b0;
  endtask

  typedef struct {
    bit ld;
    bit clr;
    int ph, pm, ps;
    int eh, em, es;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int first, nt, nd, dt;

    tbl[0] = '{1'b1, 1'b0,   5,  75,  80, 2, 59, 59};
    tbl[1] = '{1'b1, 1'b0,   1,  30,  45, 1, 30, 45};
    tbl[2] = '{1'b1, 1'b0,   2,  59,  60, 2, 59, 59};
    tbl[3] = '{1'b1, 1'b0, 255, 255, 255, 2, 59, 59};
    tbl[4] = '{1'b1, 1'b0,   0,  60,   0, 0, 59,  0};
    tbl[5] = '{1'b1, 1'b0,   1,   2,   3, 1,  2,  3};
    tbl[6] = '{1'b0, 1'b1,   0,   0,   0, 0,  0,  0};
    tbl[7] = '{1'b1, 1'b0,   3,   0,  59, 2,  0, 59};

    #1 reset = 1'b1;
    cyc(3);
    chk("reset", 64'({hours, minutes, seconds, lap_hr, lap_min, lap_sec,
                      lap_valid, running, tick, done}), 64'(0));
    reset = 1'b0;
    cyc(4);

    // Load/clear vectors while stopped
    foreach (tbl[i]) begin
      preset_hr = 8'(tbl[i].ph); preset_min = 8'(tbl[i].pm); preset_sec = 8'(tbl[i].ps);
      load = tbl[i].ld; clear = tbl[i].clr;
      @(negedge clock);
      load = 1'b0; clear = 1'b0;
      chk($sformatf("vec%0d", i), 64'({running, hours, minutes, seconds}),
          64'({1'b0, 8'(tbl[i].eh), 8'(tbl[i].em), 8'(tbl[i].es)}));
    end
    do_clear();

    // One minute of up counting
    mode = 1'b0;
    press_ss();
    chk("run_on", 64'(running), 64'(1));
    first = 0; nt = 0;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clock);
      if (tick) begin nt++; if (first == 0) first = i; end
    end
    chk("first_tick", 64'(first), 64'(4));
    chk("tick_cnt", 64'(nt), 64'(60));
    chk("one_min", 64'({running, hours, minutes, seconds}), 64'({1'b1, 8'd0, 8'd1, 8'd0}));
    press_ss();
    do_clear();
    chk("clear", 64'({hours, minutes, seconds, lap_valid, running}), 64'(0));

    // Hour wrap in up mode
    do_load(2, 59, 58);
    mode = 1'b0;
    press_ss();
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("up_wrap", 64'({running, hours, minutes, seconds}), 64'({1'b1, 24'd0}));
    chk("up_nodone", 64'(nd), 64'(0));
    press_ss();
    do_clear();

    // Down count to zero
    do_load(0, 1, 1);
    mode = 1'b1;
    press_ss();
    cyc(4);
    chk("dn_1", 64'({hours, minutes, seconds}), 64'({8'd0, 8'd1, 8'd0}));
    cyc(4);
    chk("dn_2", 64'({hours, minutes, seconds}), 64'({8'd0, 8'd0, 8'd59}));
    nd = 0; dt = 0;
    for (int i = 1; i <= 236; i++) begin
      @(negedge clock);
      if (done) begin nd++; if (tick) dt++; end
    end
    chk("dn_zero", 64'({running, hours, minutes, seconds}), 64'(0));
    chk("dn_done", 64'(nd), 64'(1));
    chk("dn_done_tick", 64'(dt), 64'(1));
    press_ss();
    cyc(3);
    chk("dn_nostart", 64'(running), 64'(0));

    // load ignored while running
    mode = 1'b0;
    do_load(1, 0, 0);
    press_ss();
    cyc(2);
    do_load(0, 0, 0);
    chk("ld_ign", 64'({running, hours, minutes, seconds}), 64'({1'b1, 8'd1, 8'd0, 8'd0}));
    cyc(1);
    chk("ld_ign_tick", 64'({running, hours, minutes, seconds}), 64'({1'b1, 8'd1, 8'd0, 8'd1}));
    press_ss();
    do_clear();

    // Pause with partial second, resume, lap, clear
    press_ss();
    cyc(4);
    chk("g_1s", 64'(seconds), 64'(1));
    press_ss();
    chk("paused", 64'(running), 64'(0));
    nt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (tick) nt++;
    end
    chk("frozen_tick", 64'(nt), 64'(0));
    chk("frozen_sec", 64'(seconds), 64'(1));
    press_ss();
    chk("resumed", 64'(running), 64'(1));
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (tick && first == 0) first = i;
    end
    chk("resume_tick", 64'(first), 64'(2));
    press_lap();
    chk("lap", 64'({lap_valid, lap_hr, lap_min, lap_sec}), 64'({1'b1, 8'd0, 8'd0, 8'd3}));
    do_clear();
    chk("lap_clear", 64'({lap_valid, lap_hr, lap_min, lap_sec, hours, minutes, seconds, running}), 64'(0));

    // Async reset mid-second with start_stop held high
    press_ss();
    cyc(5);
    start_stop = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst", 64'({hours, minutes, seconds, running, lap_valid}), 64'(0));
    cyc(2);
    reset = 1'b0;
    cyc(10);
    chk("no_edge", 64'(running), 64'(0));
    start_stop = 1'b0;
    cyc(2);
    start_stop = 1'b1;
    cyc(3);
    chk("re_arm", 64'(running), 64'(1));
    start_stop = 1'b0;
    cyc(2);
    press_ss();
    do_clear();

    // Randomized stimulus, checked every cycle by the model comparison
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 5) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 9) == 0) lap = ~lap;
      clear = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      preset_hr  = 8'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: preset_min = 8'd0;
        1: preset_min = 8'd1;
        2: preset_min = 8'd59;
        default: preset_min = 8'd60;
      endcase
      preset_sec = 8'($urandom_range(0, 61));
    end
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0; load = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
